mux4_sel_sequencer: RTL and testbench

Upstream control stage for the 4:1 gate-level mux. Drives the mux select lines s1/s0 in round-robin order over the channels requested in a 4-bit mask. Each selected channel is held for a programmable dwell time. A one-cycle break-before-make gap separates channels, and sel_valid marks when the mux output is settled and usable downstream.

---
 rtl/mux4_sel_sequencer_pkg.sv | 17 +
 rtl/mux4_sel_sequencer_if.sv | 26 ++
 rtl/mux4_sel_sequencer_rr_pick.sv | 34 +++
 rtl/mux4_sel_sequencer.sv | 99 +++++++++
 tb/tb_mux4_sel_sequencer.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/mux4_sel_sequencer_pkg.sv
// Shared encodings for the 4:1 mux select sequencer: FSM states, channel count, channel indices.
package mux4_sel_sequencer_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux4_sel_sequencer_if.sv
// Control/status bundle between the mux sequencer and its controller.
// MUX4_SEQ_CAPTURE_EN adds the mux_out sampling input and the sample capture register output.
interface mux4_sel_sequencer_if;
  logic       en;
  logic [3:0] req;
  logic       hold;
  logic       s0;
  logic       s1;
  logic       sel_valid;
  logic       ch_done;
  logic       scan_done;
`ifdef MUX4_SEQ_CAPTURE_EN
  logic       mux_out;
  logic [3:0] sample;

  modport master (output en, req, hold, mux_out,
                  input  s0, s1, sel_valid, ch_done, scan_done, sample);
  modport slave  (input  en, req, hold, mux_out,
                  output s0, s1, sel_valid, ch_done, scan_done, sample);
`else
  modport master (output en, req, hold,
                  input  s0, s1, sel_valid, ch_done, scan_done);
  modport slave  (input  en, req, hold,
                  output s0, s1, sel_valid, ch_done, scan_done);
`endif
endinterface

// File: rtl/mux4_sel_sequencer_rr_pick.sv
// Round-robin channel picker: first requested channel at or after ptr (wrapping),
// plus "last" when no request sits strictly above ptr.
module mux4_rr_pick
  import mux4_sel_sequencer_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] nxt,
  output logic       any,
  output logic       last
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    nxt   = CH_A;
    any   = |req;
    last  = 1'b1;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if ((3'(k) > {1'b0, ptr}) && req[k]) last = 1'b0;
    end
  end

endmodule

// File: rtl/mux4_sel_sequencer.sv
// Round-robin 4:1 mux select sequencer with per-channel dwell and one-cycle break-before-make gap.
// MUX4_SEQ_CAPTURE_EN adds capture of mux_out into sample[channel] at the end of each dwell.
module mux4_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  mux4_sel_sequencer_if.slave bus
);
  import mux4_sel_sequencer_pkg::*;

  state_e        state_q;
  logic [1:0]    sel_q;
  logic [1:0]    ptr_q;
  logic [1:0]    ptr_d;
  logic [CW-1:0] cnt_q;
  logic          sel_valid_q;
  logic          ch_done_q;
  logic          scan_done_q;
  logic [1:0]    pick_ptr;
  logic [1:0]    pick_nxt;
  logic          pick_any;
  logic          pick_last;
`ifdef MUX4_SEQ_CAPTURE_EN
  logic [3:0]    sample_q;
`endif

  // While dwelling the picker looks above the current channel to decide scan_done;
  // otherwise it searches from the round-robin pointer for the next channel.
  assign pick_ptr = (state_q == ST_DWELL) ? sel_q : ptr_q;
  assign ptr_d    = sel_q + 2'd1;

  mux4_rr_pick u_pick (
    .req  (bus.req),
    .ptr  (pick_ptr),
    .nxt  (pick_nxt),
    .any  (pick_any),
    .last (pick_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= CH_A;
      ptr_q       <= CH_A;
      cnt_q       <= '0;
      sel_valid_q <= 1'b0;
      ch_done_q   <= 1'b0;
      scan_done_q <= 1'b0;
`ifdef MUX4_SEQ_CAPTURE_EN
      sample_q    <= 4'b0000;
`endif
    end else begin
      ch_done_q   <= 1'b0;
      scan_done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (bus.en && pick_any) begin
            sel_q       <= pick_nxt;
            cnt_q       <= CW'(DWELL - 1);
            sel_valid_q <= 1'b1;
            state_q     <= ST_DWELL;
          end else begin
            sel_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_DWELL: begin
          if (!bus.hold) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              ch_done_q   <= 1'b1;
              scan_done_q <= pick_last;
              sel_valid_q <= 1'b0;
              ptr_q       <= ptr_d;
              state_q     <= ST_GAP;
`ifdef MUX4_SEQ_CAPTURE_EN
              sample_q[sel_q] <= bus.mux_out;
`endif
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.s0        = sel_q[0];
  assign bus.s1        = sel_q[1];
  assign bus.sel_valid = sel_valid_q;
  assign bus.ch_done   = ch_done_q;
  assign bus.scan_done = scan_done_q;
`ifdef MUX4_SEQ_CAPTURE_EN
  assign bus.sample    = sample_q;
`endif

endmodule

// File: tb/tb_mux4_sel_sequencer.sv
// Directed self-checking bench for mux4_sel_sequencer (DWELL=4 and DWELL=2 instances).
// With MUX4_SEQ_CAPTURE_EN defined the capture register is exercised as well.
module tb_mux4_sel_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4;
  logic rst2;

  mux4_sel_sequencer_if bus4();
  mux4_sel_sequencer_if bus2();

  mux4_sel_sequencer #(.DWELL(4), .CW(8)) u_dut4 (.clk(clk), .rst(rst4), .bus(bus4));
  mux4_sel_sequencer #(.DWELL(2), .CW(8)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  // Observation word: {s1, s0, sel_valid, ch_done, scan_done}
  logic [4:0] o4;
  logic [4:0] o2;
  assign o4 = {bus4.s1, bus4.s0, bus4.sel_valid, bus4.ch_done, bus4.scan_done};
  assign o2 = {bus2.s1, bus2.s0, bus2.sel_valid, bus2.ch_done, bus2.scan_done};

`ifdef MUX4_SEQ_CAPTURE_EN
  logic [3:0] cap_pat = 4'b1101;
  assign bus4.mux_out = cap_pat[{bus4.s1, bus4.s0}];
  assign bus2.mux_out = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] ob(input int ch, input bit sv, input bit cd, input bit sd);
    return {2'(ch), sv, cd, sd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus4.en = 1'b0; bus4.req = 4'b0000; bus4.hold = 1'b0;
    bus2.en = 1'b0; bus2.req = 4'b0000; bus2.hold = 1'b0;
    rst4 = 1'b1;
    rst2 = 1'b1;
    tick();
    tick();
    check_val("reset4", 32'(o4), 32'(ob(0, 0, 0, 0)));
    check_val("reset2", 32'(o2), 32'(ob(0, 0, 0, 0)));
    rst4 = 1'b0;

    // Full scan, DWELL=4: period 5, scan_done only in the gap after channel 3
    bus4.en  = 1'b1;
    bus4.req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val($sformatf("scan4_c%0d", i), 32'(o4),
                32'(ob(i / 5, (i % 5) < 4, (i % 5) == 4, (i % 5) == 4 && (i / 5) == 3)));
    end
    tick();
    check_val("scan4_wrap", 32'(o4), 32'(ob(0, 1, 0, 0)));
    for (int i = 0; i < 4; i++) tick();
    check_val("scan4_gap0", 32'(o4), 32'(ob(0, 0, 1, 0)));

    // hold for 3 cycles inside channel 1 stretches sel_valid to 7 cycles
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val($sformatf("hold_c%0d", k), 32'(o4),
                32'(ob(1, k < 7, k == 7, 0)));
      if (k == 1) bus4.hold = 1'b1;
      if (k == 4) bus4.hold = 1'b0;
    end

    // en dropped on 2nd dwell cycle of channel 2
    tick();
    check_val("endrop_d1", 32'(o4), 32'(ob(2, 1, 0, 0)));
    tick();
    check_val("endrop_d2", 32'(o4), 32'(ob(2, 1, 0, 0)));
    bus4.en = 1'b0;
    tick();
    tick();
    check_val("endrop_d4", 32'(o4), 32'(ob(2, 1, 0, 0)));
    tick();
    check_val("endrop_gap", 32'(o4), 32'(ob(2, 0, 1, 0)));
    tick();
    check_val("endrop_idle1", 32'(o4), 32'(ob(2, 0, 0, 0)));
    tick();
    check_val("endrop_idle2", 32'(o4), 32'(ob(2, 0, 0, 0)));
    bus4.en = 1'b1;
    tick();
    check_val("resume_ch3", 32'(o4), 32'(ob(3, 1, 0, 0)));
    tick();
    check_val("resume_ch3b", 32'(o4), 32'(ob(3, 1, 0, 0)));

    // reset mid-dwell of channel 3, then restart at channel 0
    rst4 = 1'b1;
    tick();
    check_val("rst_mid", 32'(o4), 32'(ob(0, 0, 0, 0)));
    rst4 = 1'b0;
    tick();
    check_val("rst_restart", 32'(o4), 32'(ob(0, 1, 0, 0)));
    for (int i = 0; i < 4; i++) tick();
    check_val("rst_gap0", 32'(o4), 32'(ob(0, 0, 1, 0)));
    tick();
    check_val("rst_next1", 32'(o4), 32'(ob(1, 1, 0, 0)));

`ifdef MUX4_SEQ_CAPTURE_EN
    rst4 = 1'b1;
    tick();
    check_val("cap_reset", 32'(bus4.sample), 32'h0);
    rst4 = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_val("cap_scandone", 32'(bus4.scan_done), 32'h1);
    check_val("cap_sample", 32'(bus4.sample), 32'hd);
`endif

    // req=0101, DWELL=2: alternate 0,2; scan_done after channel 2
    rst2 = 1'b0;
    bus2.en  = 1'b1;
    bus2.req = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val($sformatf("alt2_c%0d", i), 32'(o2),
                32'(ob(((i / 3) % 2 == 1) ? 2 : 0, (i % 3) < 2, (i % 3) == 2,
                       (i % 3) == 2 && (i / 3) % 2 == 1)));
    end

    // Single requested channel: reselected every period, scan_done on every ch_done
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    bus2.req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val($sformatf("single2_c%0d", i), 32'(o2),
                32'(ob(2, (i % 3) < 2, (i % 3) == 2, (i % 3) == 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
